// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_ctrl_if;
    logic       run;
    logic [3:0] op;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       instr_done;
    logic       fault;

    modport master (
        input  run, op, zero, mem_ready,
        output mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               state, instr_done, fault
    );

    modport slave (
        output run, op, zero, mem_ready,
        input  mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               state, instr_done, fault
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: sequences fetch, decode, execute, memory and
// writeback per opcode, with a bounded wait on every memory access.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    // state    | meaning
    // IDLE     | waiting for run
    // FETCH    | instruction read, IR/PC loaded on mem_ready
    // DECODE   | branch target precompute, dispatch on op
    // EXEC_R   | register-register ALU op
    // EXEC_I   | register-immediate ALU op
    // MEM_ADDR | effective address for LW/SW
    // MEM_RD   | data read
    // MEM_WR   | data write, retires on mem_ready
    // WB_ALU   | ALU result to register file, retire
    // WB_MEM   | load data to register file, retire
    // BRANCH   | compare, conditional PC load, retire
    // JUMP     | J/JR/JAL PC load, retire
    // FAULT    | memory timeout, held until reset
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;

    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_JR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_SUBI = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       wait_expired;
    logic       retire_next;

    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a, instr_done, fault;
    logic [2:0] alu_ctrl;

    // A miss on the last permitted wait cycle faults; a hit on it still completes.
    assign wait_expired = !bus.mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        retire_next = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_ADD;
        pc_src      = 2'b00;
        instr_done  = 1'b0;
        fault       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (bus.op)
                    4'h9:             state_d = S_BRANCH;
                    4'hA, 4'hB:       state_d = S_EXEC_I;
                    4'hC, 4'hD:       state_d = S_MEM_ADDR;
                    4'h3, 4'hE, 4'hF: state_d = S_JUMP;
                    default:          state_d = S_EXEC_R;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_d   = S_WB_ALU;
                case (bus.op)
                    OP_SUB: alu_ctrl = ALU_SUB;
                    OP_AND: alu_ctrl = ALU_AND;
                    OP_OR:  alu_ctrl = ALU_OR;
                    OP_SLL: begin alu_ctrl = ALU_SLL; alu_src_b = 2'b11; end
                    OP_SRL: begin alu_ctrl = ALU_SRL; alu_src_b = 2'b11; end
                    OP_SLT: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (bus.op == OP_SUBI) ? ALU_SUB : ALU_ADD;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (bus.mem_ready)   state_d = S_WB_MEM;
                else if (wait_expired) state_d = S_FAULT;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    instr_done  = 1'b1;
                    retire_next = 1'b1;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WB_ALU: begin
                reg_write   = 1'b1;
                reg_dst     = (bus.op == OP_ADDI || bus.op == OP_SUBI) ? 2'b00 : 2'b01;
                instr_done  = 1'b1;
                retire_next = 1'b1;
            end
            S_WB_MEM: begin
                reg_write   = 1'b1;
                mem_to_reg  = 2'b01;
                instr_done  = 1'b1;
                retire_next = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_ctrl    = ALU_SUB;
                pc_write    = bus.zero;
                pc_src      = 2'b01;
                instr_done  = 1'b1;
                retire_next = 1'b1;
            end
            S_JUMP: begin
                pc_write    = 1'b1;
                pc_src      = (bus.op == OP_JR) ? 2'b11 : 2'b10;
                if (bus.op == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                instr_done  = 1'b1;
                retire_next = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire_next) state_d = bus.run ? S_FETCH : S_IDLE;

        // Staying in a memory state only happens on a wait cycle.
        if (state_d == state_q &&
            (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR))
            wait_d = wait_q + 8'd1;
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_write  = mem_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.pc_src     = pc_src;
    assign bus.state      = state_q;
    assign bus.instr_done = instr_done;
    assign bus.fault      = fault;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max consecutive wait cycles for one memory access before fault (1..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: run  input  1  permit to start the next instruction.
REQ-005 Port: op  input  4  opcode from the instruction register: ADD=0, SUB=1, MOVE=2, JR=3, AND=4, OR=5, SLL=6, SRL=7, SLT=8, BEQ=9, ADDI=A, SUBI=B, LW=C, SW=D, J=E, JAL=F.
REQ-006 Port: zero  input  1  ALU zero flag.
REQ-007 Port: mem_ready  input  1  memory completes the current access.
REQ-008 Ports (outputs, width): mem_req 1, mem_write 1, i_or_d 1 (0=PC address, 1=ALU address), ir_write 1, pc_write 1, reg_write 1, reg_dst 2 (00 rt, 01 rd, 10 link r31), mem_to_reg 2 (00 ALU, 01 mem, 10 PC), alu_src_a 1 (0 PC, 1 reg), alu_src_b 2 (00 reg, 01 const 4, 10 imm, 11 shamt), alu_ctrl 3 (team ALU encoding), pc_src 2 (00 ALU, 01 branch target, 10 jump target, 11 register).
REQ-009 Ports: state  output  4  current state code; instr_done  output  1  one-cycle pulse on retire; fault  output  1  sticky timeout flag.

Function
REQ-010 The FSM SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11, FAULT=15.
REQ-011 Outputs SHALL be Moore-decoded from state plus op, except ir_write/pc_write in FETCH and instr_done, which are qualified by mem_ready or zero as specified.
REQ-012 In every state, outputs not listed for that state SHALL be 0 and alu_ctrl SHALL be ADD.
REQ-013 IDLE: no strobes; transition to FETCH when run=1.
REQ-014 FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01; on mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next DECODE; otherwise remain in FETCH.
REQ-015 DECODE (1 cycle): alu_src_a=0, alu_src_b=10 to precompute the branch target; next state is chosen by op: 0,1,2,4,5,6,7,8 go to EXEC_R; A,B go to EXEC_I; C,D go to MEM_ADDR; 9 goes to BRANCH; 3,E,F go to JUMP.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=11 for SLL/SRL, otherwise 00; alu_ctrl is ADD for ADD/MOVE, SUB, AND, OR, SLL, SRL, SLT per op; next WB_ALU.
REQ-017 EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD (ADDI) or SUB (SUBI); next WB_ALU.
REQ-018 WB_ALU: reg_write=1, mem_to_reg=00, reg_dst=01 for R-group and 00 for I-group; instr_done=1.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; next MEM_RD for LW, MEM_WR for SW.
REQ-020 MEM_RD: mem_req=1, i_or_d=1; on mem_ready go to WB_MEM. WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01; instr_done=1.
REQ-021 MEM_WR: mem_req=1, mem_write=1, i_or_d=1; on mem_ready: instr_done=1, retire.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, SUB; pc_write=zero, pc_src=01; instr_done=1; retire.
REQ-023 JUMP: pc_write=1; pc_src=11 for JR, 10 for J/JAL; for JAL also reg_write=1, reg_dst=10, mem_to_reg=10; instr_done=1; retire.
REQ-024 Retire: next state is FETCH if run=1, else IDLE; deasserting run never aborts an instruction in flight.
REQ-025 mem_req SHALL stay high continuously from entry of FETCH/MEM_RD/MEM_WR until the cycle mem_ready=1; mem_ready is ignored when mem_req=0.
REQ-026 An 8-bit wait counter SHALL clear on entry to each memory state and increment on every mem_ready=0 cycle there; if it reaches MEM_TIMEOUT with mem_ready still 0, next state is FAULT.
REQ-027 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access normally; completion takes priority over fault.
REQ-028 FAULT: fault=1, all strobes 0; absorbing until reset.
REQ-029 Latency with zero wait: R/I-type 4 cycles, LW 5, SW 4, BEQ/J/JR/JAL 3, counted from FETCH entry.

Reset
REQ-030 On reset assertion, state SHALL become IDLE immediately: all strobes 0, fault=0, wait counter 0, alu_ctrl=ADD; an interrupted access is abandoned with no write strobes.

Verification
REQ-031 Reset mid-MEM_WR with mem_ready=0 -> mem_write drops to 0 asynchronously; state=0 on release; no instr_done.
REQ-032 run=1, op=0 (ADD), mem_ready=1 always -> states 1,2,3,8; reg_write=1 in cycle 4; instr_done pulses once.
REQ-033 op=C (LW), 3 wait cycles on MEM_RD -> mem_req high for 4 consecutive cycles; WB_MEM with mem_to_reg=01; total 8 cycles.
REQ-034 op=9 (BEQ): zero=1 -> pc_write=1, pc_src=01; with zero=0 -> pc_write=0; both 3 cycles.
REQ-035 op=F (JAL) -> JUMP with reg_dst=10, mem_to_reg=10, pc_src=10, reg_write=1, pc_write=1.
REQ-036 MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> FAULT after 15 wait cycles, fault=1 sticky; mem_ready=1 on the 15th wait cycle -> DECODE, no fault.
